cond_branch_unit: RTL and testbench

Architectural NZVC flag register and conditional-branch resolver for the pipelined CPU. Sits alongside the EX-stage adder: it captures the adder's flag nibble when a flag-setting instruction (ADDS/SUBS/ANDS) retires from EX. It evaluates the 4-bit condition field of a B.cond sitting in ID, forwarding EX-stage flags when the producer is still in EX. It also keeps saturating counters of evaluated and taken B.cond instructions for performance measurement.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/cond_eval.sv | 46 ++++
 rtl/cond_branch_unit.sv | 71 +++++++
 tb/tb_cond_branch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the CPU condition/flag logic.
//   cond_e          : the 16 A64 condition codes as carried in a B.cond field
//   FLAG_N..FLAG_C  : bit positions inside a 4-bit NZVC flag nibble
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational condition-code evaluator.
//   cond  in  4  condition field (cond_e encoding)
//   flags in  4  NZVC flags, [3]=N [2]=Z [1]=V [0]=C
//   true  out 1  condition holds for the given flags
import cpu_pkg::*;

module cond_eval (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       true
);

    logic n, z, v, c;

    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        c = flags[FLAG_C];
    end

    always_comb begin
        true = 1'b0;
        case (cond_e'(cond))
            COND_EQ: true = z;
            COND_NE: true = ~z;
            COND_HS: true = c;
            COND_LO: true = ~c;
            COND_MI: true = n;
            COND_PL: true = ~n;
            COND_VS: true = v;
            COND_VC: true = ~v;
            COND_HI: true = c & ~z;
            COND_LS: true = ~(c & ~z);
            COND_GE: true = (n == v);
            COND_LT: true = (n != v);
            COND_GT: true = ~z & (n == v);
            COND_LE: true = ~(~z & (n == v));
            // NV behaves as AL in A64.
            COND_AL: true = 1'b1;
            COND_NV: true = 1'b1;
            default: true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// cond_branch_unit: architectural NZVC flag register, B.cond resolver with
// EX->ID flag forwarding, and saturating B.cond performance counters.
//   clk, reset      : clock; synchronous active-high reset
//   ex_flags        : NZVC from the EX adder
//   ex_set_flags    : EX instruction valid and flag-setting
//   ex_flush        : EX instruction squashed
//   stall           : pipeline stall, ID/EX held
//   id_is_bcond     : valid B.cond in ID
//   id_cond         : its condition field
//   br_taken        : B.cond in ID is taken (combinational)
//   flags_q         : architectural flag register
//   cnt_bcond       : resolved B.cond count (saturating)
//   cnt_taken       : resolved-taken B.cond count (saturating)
module cond_branch_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ex_flags,
    input  logic             ex_set_flags,
    input  logic             ex_flush,
    input  logic             stall,
    input  logic             id_is_bcond,
    input  logic [3:0]       id_cond,
    output logic             br_taken,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] cnt_bcond,
    output logic [CNT_W-1:0] cnt_taken
);

    logic       ex_wr;
    logic [3:0] eff;
    logic       cond_true;

    // A producer still in EX is younger than flags_q, so it wins the bypass.
    always_comb begin
        ex_wr = ex_set_flags & ~ex_flush;
        eff   = ex_wr ? ex_flags : flags_q;
    end

    cond_eval u_cond_eval (
        .cond  (id_cond),
        .flags (eff),
        .true  (cond_true)
    );

    always_comb begin
        br_taken = id_is_bcond & cond_true;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= '0;
            cnt_bcond <= '0;
            cnt_taken <= '0;
        end else if (!stall) begin
            if (ex_wr) begin
                flags_q <= ex_flags;
            end
            if (id_is_bcond) begin
                if (cnt_bcond != '1) begin
                    cnt_bcond <= cnt_bcond + CNT_W'(1);
                end
                if (br_taken && (cnt_taken != '1)) begin
                    cnt_taken <= cnt_taken + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: directed + randomized self-checking bench for
// cond_branch_unit (counters built 4 bits wide to reach saturation quickly).
module tb_cond_branch_unit;

    localparam int unsigned CW  = 4;
    localparam int          MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    ex_flags;
    logic          ex_set_flags;
    logic          ex_flush;
    logic          stall;
    logic          id_is_bcond;
    logic [3:0]    id_cond;
    logic          br_taken;
    logic [3:0]    flags_q;
    logic [CW-1:0] cnt_bcond;
    logic [CW-1:0] cnt_taken;

    int vectors = 0;
    int miscompares = 0;

    // reference state
    logic [3:0] m_flags = 4'b0000;
    int         m_cb = 0;
    int         m_ct = 0;

    cond_branch_unit #(.CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_flags     (ex_flags),
        .ex_set_flags (ex_set_flags),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .id_is_bcond  (id_is_bcond),
        .id_cond      (id_cond),
        .br_taken     (br_taken),
        .flags_q      (flags_q),
        .cnt_bcond    (cnt_bcond),
        .cnt_taken    (cnt_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ARM pseudo-code form: base test chosen by cond[3:1], inverted by cond[0]
    // except for 1111.
    function automatic logic ref_cond(input int c, input logic [3:0] f);
        logic n, z, v, cy, r;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c / 2)
            0: r = z;
            1: r = cy;
            2: r = n;
            3: r = v;
            4: r = cy && !z;
            5: r = (n == v);
            6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if ((c % 2 == 1) && (c != 15)) r = !r;
        return r;
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= MAX) ? MAX : x + 1;
    endfunction

    // One cycle: drive at negedge, check comb output, update model at the
    // edge, check registered outputs at the next negedge.
    task automatic step(input logic rst, input logic s, input logic fl, input logic st,
                        input logic b, input logic [3:0] fx, input logic [3:0] cnd);
        logic [3:0] eff;
        logic       tk;
        reset = rst; ex_set_flags = s; ex_flush = fl; stall = st;
        id_is_bcond = b; ex_flags = fx; id_cond = cnd;
        #1;
        eff = (s && !fl) ? fx : m_flags;
        tk  = b && ref_cond(int'(cnd), eff);
        check("br_taken", {31'd0, br_taken}, {31'd0, tk});
        @(posedge clk);
        if (rst) begin
            m_flags = 4'b0000; m_cb = 0; m_ct = 0;
        end else if (!st) begin
            if (s && !fl) m_flags = fx;
            if (b) begin
                m_cb = sat_inc(m_cb);
                if (tk) m_ct = sat_inc(m_ct);
            end
        end
        @(negedge clk);
        check("flags_q",   {28'd0, flags_q},   {28'd0, m_flags});
        check("cnt_bcond", {28'd0, cnt_bcond}, 32'(m_cb));
        check("cnt_taken", {28'd0, cnt_taken}, 32'(m_ct));
    endtask

    initial begin
        reset = 1'b1; ex_flags = '0; ex_set_flags = 1'b0; ex_flush = 1'b0;
        stall = 1'b0; id_is_bcond = 1'b0; id_cond = '0;
        @(negedge clk);

        // reset, decode on flags_q=0000 during reset
        step(1, 0, 0, 0, 1, 4'h0, 4'b0001);
        check("rst_flags", {28'd0, flags_q}, 32'd0);
        check("rst_cnt", {28'd0, cnt_bcond}, 32'd0);

        // EQ not taken, NE taken, no EX write (stall keeps counters 0)
        step(0, 0, 0, 1, 1, 4'h0, 4'b0000);
        step(0, 0, 0, 1, 1, 4'h0, 4'b0001);
        check("post_reset_cnt", {28'd0, cnt_bcond}, 32'd0);

        // forwarding Z to B.EQ
        step(0, 1, 0, 0, 1, 4'b0100, 4'b0000);
        check("fwd_flags", {28'd0, flags_q}, 32'h4);
        check("fwd_cnt_t", {28'd0, cnt_taken}, 32'd1);

        // flush beats write
        step(0, 1, 1, 0, 1, 4'b0000, 4'b0000);
        check("flush_hold", {28'd0, flags_q}, 32'h4);

        // stall hold, then release
        step(0, 1, 0, 1, 1, 4'b1000, 4'b1011);
        check("stall_hold", {28'd0, flags_q}, 32'h4);
        step(0, 1, 0, 0, 1, 4'b1000, 4'b1011);
        check("stall_rel", {28'd0, flags_q}, 32'h8);

        // full flags x cond sweep via forwarding, stalled so nothing commits
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                ex_set_flags = 1'b1; ex_flush = 1'b0; stall = 1'b1; reset = 1'b0;
                id_is_bcond = 1'b1; ex_flags = 4'(f); id_cond = 4'(c);
                #1;
                check("sweep", {31'd0, br_taken}, {31'd0, ref_cond(c, 4'(f))});
            end
        end
        ex_flags = 4'b1010;
        id_cond = 4'b1010; #1; check("spot_ge", {31'd0, br_taken}, 32'd1);
        id_cond = 4'b1011; #1; check("spot_lt", {31'd0, br_taken}, 32'd0);
        id_cond = 4'b1100; #1; check("spot_gt", {31'd0, br_taken}, 32'd1);
        ex_flags = 4'b0011;
        id_cond = 4'b1000; #1; check("spot_hi", {31'd0, br_taken}, 32'd1);
        id_cond = 4'b1010; #1; check("spot_ge2", {31'd0, br_taken}, 32'd0);
        @(negedge clk);

        // saturation
        step(1, 0, 0, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 4'h0, 4'b1110);
        check("sat_bcond", {28'd0, cnt_bcond}, 32'd15);
        check("sat_taken", {28'd0, cnt_taken}, 32'd15);
        step(0, 1, 0, 0, 1, 4'b1111, 4'b1110);
        step(1, 1, 0, 0, 1, 4'b0110, 4'b1110);
        check("midrst_cnt", {28'd0, cnt_bcond}, 32'd0);
        check("midrst_flags", {28'd0, flags_q}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 60) == 0, $urandom % 2, ($urandom % 4) == 0,
                 ($urandom % 4) == 0, ($urandom % 3) != 0,
                 4'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
